piece_move_ctrl: RTL and testbench
==================================

// Module: piece_move_ctrl
// PURPOSE
//  Sequences the combinational block_check collision datapath for the active
//  piece. Arbitrates spawn, gravity and player requests (left/right/rotate/
//  soft drop) and drives a candidate (x, y, rotate) to block_check. Commits
//  the candidate when it fits. When a downward move fails, it signals lock.
//  It sits between the input/gravity-timer logic and the field-merge logic.
// PARAMETERS
//  FIELD_W  20  field width in cells; field bit index = y*20 + x
//  FIELD_H  20  field height in cells
//  SPAWN_X  8   x of a newly spawned piece (4x4 box origin)
//  SPAWN_Y  0   y of a newly spawned piece
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  spawn_req    in   1  request a new piece (honoured only in EMPTY)
//  grav_tick    in   1  one-cycle gravity pulse
//  move_left    in   1  player left, sampled in READY only
//  move_right   in   1  player right, sampled in READY only
//  rotate_cw    in   1  player rotate, sampled in READY only
//  soft_drop    in   1  player down, sampled in READY only
//  chk_ok       in   1  block_check_result (1 = candidate fits)
//  chk_pos_x    out  5  candidate x to block_check (registered)
//  chk_pos_y    out  5  candidate y to block_check (registered)
//  chk_rotate   out  3  candidate rotate to block_check, always 0..3
//  pos_x        out  5  committed piece x
//  pos_y        out  5  committed piece y
//  rot          out  3  committed rotation, 0..3
//  piece_active out  1  a piece is live (READY or CHECK after a spawn)
//  busy         out  1  1 while in CHECK or SPAWN
//  lock_pulse   out  1  one cycle: piece at pos_x/pos_y/rot must merge
//  game_over    out  1  sticky: spawn collided
// BEHAVIOUR
//  Reset: all outputs 0, state EMPTY, grav_pend 0. Reset is async at any
//   time, including mid-CHECK; no partial commit survives it.
//  States:
//   EMPTY: on spawn_req, load cand = (SPAWN_X, SPAWN_Y, 0) and go to SPAWN.
//   SPAWN: sample chk_ok. If 1: commit, piece_active=1, go to READY.
//    If 0: game_over=1 and go to OVER.
//   READY: serve one request, chosen by fixed priority:
//    grav_pend|grav_tick > soft_drop > rotate_cw > left > right.
//    The chosen request loads cand and goes to CHECK. The load kind is
//    remembered: DOWN for gravity or soft drop, SIDE otherwise.
//   CHECK: sample chk_ok at the end of the cycle.
//    If 1: pos/rot <= cand.
//    If 0 and DOWN: lock_pulse=1, piece_active=0, go to EMPTY.
//    If 0 and SIDE: discard cand.
//    Otherwise return to READY.
//   OVER: ignore all inputs until reset.
//  Candidates: down = y+1; left = x-1; right = x+1; rotate = (rot+1) mod 4.
//   No other field changes.
//  Latency: request seen in READY -> pos/rot updated 2 cycles later.
//   cand is stable for the whole CHECK/SPAWN cycle.
//  Bounds:
//   left at pos_x==0 is dropped in READY, with no check and no state change.
//   right/down/rotate are always sent to block_check, which rejects
//    out-of-range cells (x>=FIELD_W or y>=FIELD_H). 5-bit x+1 and y+1
//    never exceed 20, so they do not wrap.
//  Conflicts:
//   move_left and move_right together: both are ignored.
//   grav_tick while busy, or not chosen in READY: sets grav_pend. grav_pend
//    clears when gravity is served. In EMPTY, grav_tick is ignored.
//   Player inputs while busy are dropped, not queued.
//  Upstream must hold field constant from lock_pulse until the next
//   spawn_req is issued.
// TESTING
//  1 Reset: assert rst_n=0 mid-CHECK -> all outputs 0 immediately; state
//    EMPTY; the next grav_tick is ignored.
//  2 Spawn: spawn_req=1 with chk_ok=1 -> 2 cycles later pos=(8,0), rot=0,
//    piece_active=1, busy=0.
//  3 Left: move_left at pos_x=0 -> busy stays 0 and pos is unchanged.
//    move_left at pos_x=5 with chk_ok=1 -> pos_x=4 after 2 cycles.
//    move_left+move_right together -> no change.
//  4 Lock: grav_tick at y=17 with chk_ok=0 -> lock_pulse high for exactly
//    1 cycle, pos stays (x,17), piece_active=0, state EMPTY.
//  5 Pended gravity: rotate_cw at rot=3, then grav_tick during its CHECK,
//    all chk_ok=1 -> rot=0, then y+1 two cycles later; grav_pend clears.
//  6 Game over: spawn with chk_ok=0 -> game_over=1 sticky; later spawn_req
//    and moves are ignored until rst_n is pulsed.

Source files
------------

// File: rtl/piece_move_ctrl.sv
// Active-piece move sequencer: arbitrates spawn/gravity/player requests,
// drives a candidate to block_check and commits or locks on the result.
module piece_move_ctrl #(
   parameter int unsigned FIELD_W = 20,
   parameter int unsigned FIELD_H = 20,
   parameter int unsigned SPAWN_X = 8,
   parameter int unsigned SPAWN_Y = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spawn_req,
   input  logic       grav_tick,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       rotate_cw,
   input  logic       soft_drop,
   input  logic       chk_ok,
   output logic [4:0] chk_pos_x,
   output logic [4:0] chk_pos_y,
   output logic [2:0] chk_rotate,
   output logic [4:0] pos_x,
   output logic [4:0] pos_y,
   output logic [2:0] rot,
   output logic       piece_active,
   output logic       busy,
   output logic       lock_pulse,
   output logic       game_over
);

   // Field bounds are enforced by block_check, not here.
   localparam int unsigned unused_dims = FIELD_W + FIELD_H;

   typedef enum logic [2:0] {
      S_EMPTY,
      S_SPAWN,
      S_READY,
      S_CHECK,
      S_OVER
   } state_e;

   state_e     state_q, state_d;
   logic [4:0] cx_q, cx_d, cy_q, cy_d;
   logic [2:0] cr_q, cr_d;
   logic [4:0] px_q, px_d, py_q, py_d;
   logic [2:0] pr_q, pr_d;
   logic       act_q, act_d;
   logic       pend_q, pend_d;
   logic       down_q, down_d;
   logic       lock_q, lock_d;
   logic       over_q, over_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
         cx_q    <= '0;
         cy_q    <= '0;
         cr_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         pr_q    <= '0;
         act_q   <= 1'b0;
         pend_q  <= 1'b0;
         down_q  <= 1'b0;
         lock_q  <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         cr_q    <= cr_d;
         px_q    <= px_d;
         py_q    <= py_d;
         pr_q    <= pr_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
         down_q  <= down_d;
         lock_q  <= lock_d;
         over_q  <= over_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      cr_d    = cr_q;
      px_d    = px_q;
      py_d    = py_q;
      pr_d    = pr_q;
      act_d   = act_q;
      pend_d  = pend_q;
      down_d  = down_q;
      lock_d  = 1'b0;
      over_d  = over_q;
      unique case (state_q)
         S_EMPTY: begin
            if (spawn_req) begin
               cx_d    = 5'(SPAWN_X);
               cy_d    = 5'(SPAWN_Y);
               cr_d    = 3'd0;
               state_d = S_SPAWN;
            end
         end
         S_SPAWN: begin
            if (grav_tick) pend_d = 1'b1;
            if (chk_ok) begin
               px_d    = cx_q;
               py_d    = cy_q;
               pr_d    = cr_q;
               act_d   = 1'b1;
               state_d = S_READY;
            end else begin
               over_d  = 1'b1;
               state_d = S_OVER;
            end
         end
         S_READY: begin
            if (pend_q || grav_tick) begin
               cx_d    = px_q;
               cy_d    = py_q + 5'd1;
               cr_d    = pr_q;
               down_d  = 1'b1;
               pend_d  = 1'b0;
               state_d = S_CHECK;
            end else if (soft_drop) begin
               cx_d    = px_q;
               cy_d    = py_q + 5'd1;
               cr_d    = pr_q;
               down_d  = 1'b1;
               state_d = S_CHECK;
            end else if (rotate_cw) begin
               cx_d    = px_q;
               cy_d    = py_q;
               cr_d    = {1'b0, pr_q[1:0] + 2'd1};
               down_d  = 1'b0;
               state_d = S_CHECK;
            end else if (move_left && !move_right && px_q != 5'd0) begin
               cx_d    = px_q - 5'd1;
               cy_d    = py_q;
               cr_d    = pr_q;
               down_d  = 1'b0;
               state_d = S_CHECK;
            end else if (move_right && !move_left) begin
               cx_d    = px_q + 5'd1;
               cy_d    = py_q;
               cr_d    = pr_q;
               down_d  = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (grav_tick) pend_d = 1'b1;
            state_d = S_READY;
            if (chk_ok) begin
               px_d = cx_q;
               py_d = cy_q;
               pr_d = cr_q;
            end else if (down_q) begin
               // Pending gravity belonged to the piece now being merged.
               lock_d  = 1'b1;
               act_d   = 1'b0;
               pend_d  = 1'b0;
               state_d = S_EMPTY;
            end
         end
         S_OVER: begin
            state_d = S_OVER;
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   assign chk_pos_x    = cx_q;
   assign chk_pos_y    = cy_q;
   assign chk_rotate   = cr_q;
   assign pos_x        = px_q;
   assign pos_y        = py_q;
   assign rot          = pr_q;
   assign piece_active = act_q;
   assign busy         = (state_q == S_CHECK) || (state_q == S_SPAWN);
   assign lock_pulse   = lock_q;
   assign game_over    = over_q;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Scoreboard bench for piece_move_ctrl: directed requests push expected
// responses; a monitor checks each completed SPAWN/CHECK.
module tb_piece_move_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spawn_req, grav_tick, move_left, move_right;
   logic       rotate_cw, soft_drop, chk_ok;
   logic [4:0] chk_pos_x, chk_pos_y, pos_x, pos_y;
   logic [2:0] chk_rotate, rot;
   logic       piece_active, busy, lock_pulse, game_over;
   logic [29:0] outs;

   always #5 clk = ~clk;

   piece_move_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spawn_req    (spawn_req),
      .grav_tick    (grav_tick),
      .move_left    (move_left),
      .move_right   (move_right),
      .rotate_cw    (rotate_cw),
      .soft_drop    (soft_drop),
      .chk_ok       (chk_ok),
      .chk_pos_x    (chk_pos_x),
      .chk_pos_y    (chk_pos_y),
      .chk_rotate   (chk_rotate),
      .pos_x        (pos_x),
      .pos_y        (pos_y),
      .rot          (rot),
      .piece_active (piece_active),
      .busy         (busy),
      .lock_pulse   (lock_pulse),
      .game_over    (game_over)
   );

   assign outs = {chk_pos_x, chk_pos_y, chk_rotate, pos_x, pos_y, rot,
                  piece_active, busy, lock_pulse, game_over};

   typedef struct {
      logic [4:0] cx;
      logic [4:0] cy;
      logic [2:0] cr;
      logic [4:0] px;
      logic [4:0] py;
      logic [2:0] pr;
      logic       act;
      logic       lock;
      logic       over;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic exp_t mk(input int cx, input int cy, input int cr,
                               input int px, input int py, input int pr,
                               input int act, input int lock, input int over);
      exp_t e;
      e.cx   = 5'(cx);
      e.cy   = 5'(cy);
      e.cr   = 3'(cr);
      e.px   = 5'(px);
      e.py   = 5'(py);
      e.pr   = 3'(pr);
      e.act  = 1'(act);
      e.lock = 1'(lock);
      e.over = 1'(over);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Monitor: one response per busy->idle transition
   logic       prev_busy = 1'b0;
   logic [4:0] m_cx, m_cy;
   logic [2:0] m_cr;
   exp_t       m_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_busy = 1'b0;
      end else begin
         if (prev_busy && !busy) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_response: pos %0d,%0d none expected",
                        pos_x, pos_y);
            end else begin
               m_e = sb.pop_front();
               chk("cand_x", 32'(m_cx), 32'(m_e.cx));
               chk("cand_y", 32'(m_cy), 32'(m_e.cy));
               chk("cand_rot", 32'(m_cr), 32'(m_e.cr));
               chk("pos_x", 32'(pos_x), 32'(m_e.px));
               chk("pos_y", 32'(pos_y), 32'(m_e.py));
               chk("rot", 32'(rot), 32'(m_e.pr));
               chk("piece_active", 32'(piece_active), 32'(m_e.act));
               chk("lock_pulse", 32'(lock_pulse), 32'(m_e.lock));
               chk("game_over", 32'(game_over), 32'(m_e.over));
            end
         end
         if (busy) begin
            m_cx = chk_pos_x;
            m_cy = chk_pos_y;
            m_cr = chk_rotate;
         end
         prev_busy = busy;
      end
   end

   task automatic clr();
      spawn_req  = 1'b0;
      grav_tick  = 1'b0;
      move_left  = 1'b0;
      move_right = 1'b0;
      rotate_cw  = 1'b0;
      soft_drop  = 1'b0;
   endtask

   task automatic req(input logic sp, input logic gt, input logic sd,
                      input logic rc, input logic ml, input logic mr,
                      input logic ok, input exp_t e);
      @(negedge clk);
      spawn_req  = sp;
      grav_tick  = gt;
      soft_drop  = sd;
      rotate_cw  = rc;
      move_left  = ml;
      move_right = mr;
      chk_ok     = ok;
      sb.push_back(e);
      @(negedge clk);
      clr();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      clr();
      chk_ok = 1'b0;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'(outs), 32'd0);
      rst_n = 1'b1;

      req(1, 0, 0, 0, 0, 0, 1, mk(8, 0, 0, 8, 0, 0, 1, 0, 0));
      for (int i = 7; i >= 0; i--)
         req(0, 0, 0, 0, 1, 0, 1, mk(i, 0, 0, i, 0, 0, 1, 0, 0));

      @(negedge clk);
      move_left = 1'b1;
      @(negedge clk);
      clr();
      chk("left_at_0_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("left_at_0_busy2", 32'(busy), 32'd0);
      chk("left_at_0_pos", 32'(pos_x), 32'd0);

      move_left  = 1'b1;
      move_right = 1'b1;
      @(negedge clk);
      clr();
      chk("left_right_busy", 32'(busy), 32'd0);
      chk("left_right_pos", 32'(pos_x), 32'd0);

      req(0, 0, 0, 0, 0, 1, 1, mk(1, 0, 0, 1, 0, 0, 1, 0, 0));
      req(0, 0, 0, 0, 1, 0, 0, mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
      for (int r = 1; r <= 3; r++)
         req(0, 0, 0, 1, 0, 0, 1, mk(1, 0, r, 1, 0, r, 1, 0, 0));

      @(negedge clk);
      rotate_cw = 1'b1;
      chk_ok    = 1'b1;
      sb.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0));
      sb.push_back(mk(1, 1, 0, 1, 1, 0, 1, 0, 0));
      @(negedge clk);
      rotate_cw = 1'b0;
      grav_tick = 1'b1;
      chk("pend_rot_busy", 32'(busy), 32'd1);
      @(negedge clk);
      grav_tick = 1'b0;
      @(negedge clk);
      chk("pend_grav_busy", 32'(busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("pend_cleared", 32'(busy), 32'd0);

      req(0, 0, 1, 1, 0, 0, 1, mk(1, 2, 0, 1, 2, 0, 1, 0, 0));
      req(0, 1, 1, 0, 0, 0, 1, mk(1, 3, 0, 1, 3, 0, 1, 0, 0));
      @(negedge clk);
      chk("grav_sd_no_pend", 32'(busy), 32'd0);
      for (int y = 4; y <= 17; y++)
         req(0, 0, 1, 0, 0, 0, 1, mk(1, y, 0, 1, y, 0, 1, 0, 0));

      req(0, 1, 0, 0, 0, 0, 0, mk(1, 18, 0, 1, 17, 0, 0, 1, 0));
      @(negedge clk);
      chk("lock_one_cycle", 32'(lock_pulse), 32'd0);
      chk("lock_inactive", 32'(piece_active), 32'd0);
      chk("lock_pos_y", 32'(pos_y), 32'd17);
      grav_tick = 1'b1;
      @(negedge clk);
      clr();
      chk("empty_grav_ignored", 32'(busy), 32'd0);

      req(1, 0, 0, 0, 0, 0, 1, mk(8, 0, 0, 8, 0, 0, 1, 0, 0));
      @(negedge clk);
      move_right = 1'b1;
      chk_ok     = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_mid_check", 32'(outs), 32'd0);
      clr();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      grav_tick = 1'b1;
      @(negedge clk);
      clr();
      chk("reset_grav_ignored", 32'(busy), 32'd0);
      @(negedge clk);
      chk("reset_grav_outs", 32'(outs), 32'd0);

      req(1, 0, 0, 0, 0, 0, 0, mk(8, 0, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      spawn_req  = 1'b1;
      move_right = 1'b1;
      grav_tick  = 1'b1;
      chk_ok     = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("over_busy", 32'(busy), 32'd0);
         chk("over_sticky", 32'(game_over), 32'd1);
         chk("over_inactive", 32'(piece_active), 32'd0);
      end
      clr();
      rst_n = 1'b0;
      #1;
      chk("over_reset", 32'(game_over), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req(1, 0, 0, 0, 0, 0, 1, mk(8, 0, 0, 8, 0, 0, 1, 0, 0));

      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
